alu_instr_controller: RTL and testbench
=======================================

// Module: alu_instr_controller
// PURPOSE
//   Hardwired Moore control unit that sequences the datapath through instruction fetch
//   (T0-T2) and execution (T3-T6).
//   Executes register ALU ops, mul/div, neg/not, nop and halt.
//   Drives the same register-transfer strobes a bench would otherwise toggle by hand.
//   Sits beside the datapath: IR contents come in; one-hot Rin/Rout, Z/HI/LO, memory and ALU opcode strobes go out.
// PARAMETERS
//   MEM_WAIT  0  extra T1 cycles Read/MDRin are held for slow memory (0..7)
// PORTS
//   clock      in   1   system clock; all state changes on posedge
//   clear      in   1   asynchronous, active-low reset
//   run        in   1   level; 1 = fetch/execute instructions, 0 = park in IDLE after current instr
//   ir         in   32  IR register contents; opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15]
//   PCout, PCin, MARin, MDRin, MDRout, Read, IRin, Yin  out 1  datapath strobes
//   ZlowIn, ZhighIn, Zlowout, Zhighout, HIin, LOin      out 1  Z/HI/LO strobes
//   Rin        out  16  one-hot general register load enables
//   Rout       out  16  one-hot general register bus drives
//   opcode     out  5   ALU operation select
//   illegal    out  1   sticky: unsupported opcode executed
//   halted     out  1   1 while in HALT
//   state_dbg  out  4   current state encoding
// BEHAVIOUR
// - State register plus MEM_WAIT counter on posedge clock.
// - Outputs decode combinationally from state/ir/counter and are valid for the whole state cycle.
// - Reset (clear=0, async, any state):
//   - state=IDLE, counter=0, illegal=0; every output 0 immediately.
//   - Resumes on the first posedge after clear=1.
// - States: IDLE, T0..T6, HALT.
//   - Any strobe not listed for a state is 0; opcode=00000 unless listed.
// - IDLE: all 0. run=1 -> T0, else stay.
// - T0: PCout, MARin, opcode=11111 (PC+1), ZlowIn. -> T1.
// - T1: Read, MDRin every cycle.
//   - Zlowout and PCin only when counter==0.
//   - counter<MEM_WAIT: counter++ and stay; else counter=0 -> T2.
// - T2: MDRout, IRin. -> T3. IR is valid from T3 until next T2.
// - T3: decode ir[31:27]:
//   - ALU3 (00011 add .. 01011 shl): Rout[Rb], Yin. -> T4.
//   - MULDIV (01111 mul, 10000 div): Rout[Ra], Yin. -> T4.
//   - UNARY (10001 neg, 10010 not): Rout[Rb], opcode=ir[31:27], ZlowIn. -> T4.
//   - 11010 nop: no strobes. -> END.
//   - 11011 halt: no strobes. -> HALT.
//   - anything else: no strobes; illegal<=1. -> END.
// - T4:
//   - ALU3: Rout[Rc], opcode=ir[31:27], ZlowIn. -> T5.
//   - MULDIV: Rout[Rb], opcode=ir[31:27], ZlowIn, ZhighIn. -> T5.
//   - UNARY: Zlowout, Rin[Ra]. -> END.
// - T5:
//   - ALU3: Zlowout, Rin[Ra]. -> END.
//   - MULDIV: Zlowout, LOin. -> T6.
// - T6 (MULDIV only): Zhighout, HIin. -> END.
// - END (the transition taken from the final state of an instruction): run=1 -> T0, run=0 -> IDLE.
//   - run is sampled only at END and in IDLE; dropping it mid-instruction never aborts.
// - HALT: all strobes 0, halted=1. Exits only via clear.
// - Rin/Rout: at most one bit set; index is the 4-bit field. Ra=Rb is legal (same bit).
// - illegal: cleared only by reset. Never blocks further instructions.
// TESTING
// - add r4,r3,r7: ir=0x1A1B8000, run=1 -> IDLE,T0..T5.
//   - T3 Rout=0x0008+Yin; T4 Rout=0x0080, opcode=00011, ZlowIn.
//   - T5 Zlowout, Rin=0x0010; next cycle T0.
// - sub r4,r3,r7: ir=0x221B8000 -> T4 opcode=00100; else identical to add. Drop run in T4 -> IDLE after T5.
// - mul r3,r7: ir=0x79B80000 -> T3 Rout=0x0008; T4 Rout=0x0080, opcode=01111, ZlowIn+ZhighIn.
//   - T5 Zlowout+LOin; T6 Zhighout+HIin.
// - MEM_WAIT=2: T1 lasts 3 cycles with Read/MDRin each cycle; PCin/Zlowout only in the first; T2 on 4th cycle.
// - halt: ir=0xD8000000 -> T3 then HALT; halted=1, all strobes 0, toggling run ignored; clear=0 -> IDLE.
// - illegal/reset: ir=0x00000000 -> illegal=1 after T3, no Rin pulse, next T0.
//   - clear=0 mid-T4 of add -> all outputs 0 within same cycle, illegal=0.

Source files
------------

// File: rtl/alu_instr_controller.sv
// Hardwired Moore control unit: fetch (T0-T2) and execute (T3-T6) sequencing for the datapath.
// state_dbg encoding: IDLE=0, T0..T6=1..7, HALT=8.
module alu_instr_controller #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        ZlowIn,
    output logic        ZhighIn,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  opcode,
    output logic        illegal,
    output logic        halted,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_ALU3,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT,
        C_BAD
    } iclass_t;

    localparam logic [2:0] WAIT_C = 3'(MEM_WAIT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        illegal_q, illegal_d;
    iclass_t     iclass;
    logic [4:0]  op;
    logic [15:0] ra_1h, rb_1h, rc_1h;
    state_t      end_next;
    logic        unused_ir;

    assign op        = ir[31:27];
    assign ra_1h     = 16'd1 << ir[26:23];
    assign rb_1h     = 16'd1 << ir[22:19];
    assign rc_1h     = 16'd1 << ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign end_next  = run ? S_T0 : S_IDLE;

    always_comb begin
        if (op >= 5'd3 && op <= 5'd11)           iclass = C_ALU3;
        else if (op == 5'd15 || op == 5'd16)     iclass = C_MULDIV;
        else if (op == 5'd17 || op == 5'd18)     iclass = C_UNARY;
        else if (op == 5'd26)                    iclass = C_NOP;
        else if (op == 5'd27)                    iclass = C_HALT;
        else                                     iclass = C_BAD;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        PCout     = 1'b0;
        PCin      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        Read      = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ZlowIn    = 1'b0;
        ZhighIn   = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Rin       = '0;
        Rout      = '0;
        opcode    = '0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE: state_d = end_next;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                ZlowIn  = 1'b1;
                opcode  = '1;
                state_d = S_T1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                // PC update happens once, on the first cycle of the memory wait
                if (cnt_q == '0) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
                if (cnt_q < WAIT_C) begin
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    cnt_d   = '0;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                case (iclass)
                    C_ALU3: begin
                        Rout    = rb_1h;
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                    C_MULDIV: begin
                        Rout    = ra_1h;
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                    C_UNARY: begin
                        Rout    = rb_1h;
                        opcode  = op;
                        ZlowIn  = 1'b1;
                        state_d = S_T4;
                    end
                    C_NOP:  state_d = end_next;
                    C_HALT: state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = end_next;
                    end
                endcase
            end
            S_T4: begin
                case (iclass)
                    C_ALU3: begin
                        Rout    = rc_1h;
                        opcode  = op;
                        ZlowIn  = 1'b1;
                        state_d = S_T5;
                    end
                    C_MULDIV: begin
                        Rout    = rb_1h;
                        opcode  = op;
                        ZlowIn  = 1'b1;
                        ZhighIn = 1'b1;
                        state_d = S_T5;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1;
                        Rin     = ra_1h;
                        state_d = end_next;
                    end
                    default: state_d = end_next;
                endcase
            end
            S_T5: begin
                case (iclass)
                    C_ALU3: begin
                        Zlowout = 1'b1;
                        Rin     = ra_1h;
                        state_d = end_next;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                        state_d = S_T6;
                    end
                    default: state_d = end_next;
                endcase
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = end_next;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_instr_controller.sv
// Bench for alu_instr_controller: directed vector table, multi-cycle corner sequences,
// and a randomized run against a per-cycle expected-strobe queue model.
module tb_alu_instr_controller;

    localparam logic [13:0] PCOUT = 14'h2000, PCIN = 14'h1000, MARIN = 14'h0800, MDRIN = 14'h0400;
    localparam logic [13:0] MDROUT = 14'h0200, READ = 14'h0100, IRIN = 14'h0080, YIN = 14'h0040;
    localparam logic [13:0] ZLOWIN = 14'h0020, ZHIGHIN = 14'h0010, ZLOWOUT = 14'h0008;
    localparam logic [13:0] ZHIGHOUT = 14'h0004, HIIN = 14'h0002, LOIN = 14'h0001;
    localparam logic [13:0] F_T0 = PCOUT | MARIN | ZLOWIN;
    localparam logic [13:0] F_T1 = READ | MDRIN | ZLOWOUT | PCIN;
    localparam logic [13:0] F_T2 = MDROUT | IRIN;
    localparam logic [31:0] ADD = 32'h1A1B8000, SUB = 32'h221B8000, MUL = 32'h79B80000;
    localparam logic [31:0] BAD = 32'h00000000, HLT = 32'hD8000000;

    logic clock = 1'b0;
    logic clear = 1'b0;
    logic run = 1'b0;
    logic [31:0] ir = '0;

    logic a_PCout, a_PCin, a_MARin, a_MDRin, a_MDRout, a_Read, a_IRin, a_Yin;
    logic a_ZlowIn, a_ZhighIn, a_Zlowout, a_Zhighout, a_HIin, a_LOin, a_illegal, a_halted;
    logic [15:0] a_Rin, a_Rout;
    logic [4:0] a_opcode;
    logic [3:0] a_state;
    logic b_PCout, b_PCin, b_MARin, b_MDRin, b_MDRout, b_Read, b_IRin, b_Yin;
    logic b_ZlowIn, b_ZhighIn, b_Zlowout, b_Zhighout, b_HIin, b_LOin, b_illegal, b_halted;
    logic [15:0] b_Rin, b_Rout;
    logic [4:0] b_opcode;
    logic [3:0] b_state;

    always #5 clock = ~clock;

    alu_instr_controller dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir),
        .PCout(a_PCout), .PCin(a_PCin), .MARin(a_MARin), .MDRin(a_MDRin), .MDRout(a_MDRout),
        .Read(a_Read), .IRin(a_IRin), .Yin(a_Yin), .ZlowIn(a_ZlowIn), .ZhighIn(a_ZhighIn),
        .Zlowout(a_Zlowout), .Zhighout(a_Zhighout), .HIin(a_HIin), .LOin(a_LOin),
        .Rin(a_Rin), .Rout(a_Rout), .opcode(a_opcode), .illegal(a_illegal),
        .halted(a_halted), .state_dbg(a_state)
    );

    alu_instr_controller #(.MEM_WAIT(2)) dut_w (
        .clock(clock), .clear(clear), .run(run), .ir(ir),
        .PCout(b_PCout), .PCin(b_PCin), .MARin(b_MARin), .MDRin(b_MDRin), .MDRout(b_MDRout),
        .Read(b_Read), .IRin(b_IRin), .Yin(b_Yin), .ZlowIn(b_ZlowIn), .ZhighIn(b_ZhighIn),
        .Zlowout(b_Zlowout), .Zhighout(b_Zhighout), .HIin(b_HIin), .LOin(b_LOin),
        .Rin(b_Rin), .Rout(b_Rout), .opcode(b_opcode), .illegal(b_illegal),
        .halted(b_halted), .state_dbg(b_state)
    );

    logic [55:0] obs0, obsw;
    assign obs0 = {a_PCout, a_PCin, a_MARin, a_MDRin, a_MDRout, a_Read, a_IRin, a_Yin,
                   a_ZlowIn, a_ZhighIn, a_Zlowout, a_Zhighout, a_HIin, a_LOin,
                   a_Rin, a_Rout, a_opcode, a_state, a_halted};
    assign obsw = {b_PCout, b_PCin, b_MARin, b_MDRin, b_MDRout, b_Read, b_IRin, b_Yin,
                   b_ZlowIn, b_ZhighIn, b_Zlowout, b_Zhighout, b_HIin, b_LOin,
                   b_Rin, b_Rout, b_opcode, b_state, b_halted};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic [55:0] mkobs(input logic [13:0] s, input logic [15:0] rin,
                                          input logic [15:0] rout, input logic [4:0] op,
                                          input logic [3:0] st);
        return {s, rin, rout, op, st, st == 4'd8};
    endfunction

    // ---------------- behavioural model: queue of per-cycle expected strobes ----------------
    typedef struct packed {
        logic [13:0] s;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
        logic [3:0]  st;
        logic        set_ill;
        logic        to_halt;
    } bnd_t;

    bnd_t mq[$];
    logic m_halt = 1'b0;
    logic m_ill = 1'b0;

    function automatic bnd_t mb(input logic [13:0] s, input logic [15:0] rin,
                                input logic [15:0] rout, input logic [4:0] op,
                                input logic [3:0] st);
        bnd_t b;
        b.s = s; b.rin = rin; b.rout = rout; b.op = op; b.st = st;
        b.set_ill = 1'b0; b.to_halt = 1'b0;
        return b;
    endfunction

    function automatic bnd_t m_cur();
        if (m_halt) return mb('0, '0, '0, '0, 4'd8);
        if (mq.size() == 0) return mb('0, '0, '0, '0, 4'd0);
        return mq[0];
    endfunction

    function automatic logic [55:0] bobs(input bnd_t b);
        return mkobs(b.s, b.rin, b.rout, b.op, b.st);
    endfunction

    task automatic push_fetch();
        mq.push_back(mb(F_T0, '0, '0, 5'h1f, 4'd1));
        mq.push_back(mb(F_T1, '0, '0, '0, 4'd2));
        mq.push_back(mb(F_T2, '0, '0, '0, 4'd3));
    endtask

    task automatic push_exec(input logic [31:0] i);
        int unsigned opv;
        logic [15:0] a, b, c;
        bnd_t t;
        opv = int'(i[31:27]);
        a = 16'd1 << i[26:23];
        b = 16'd1 << i[22:19];
        c = 16'd1 << i[18:15];
        if (opv >= 3 && opv <= 11) begin
            mq.push_back(mb(YIN, '0, b, '0, 4'd4));
            mq.push_back(mb(ZLOWIN, '0, c, i[31:27], 4'd5));
            mq.push_back(mb(ZLOWOUT, a, '0, '0, 4'd6));
        end else if (opv == 15 || opv == 16) begin
            mq.push_back(mb(YIN, '0, a, '0, 4'd4));
            mq.push_back(mb(ZLOWIN | ZHIGHIN, '0, b, i[31:27], 4'd5));
            mq.push_back(mb(ZLOWOUT | LOIN, '0, '0, '0, 4'd6));
            mq.push_back(mb(ZHIGHOUT | HIIN, '0, '0, '0, 4'd7));
        end else if (opv == 17 || opv == 18) begin
            mq.push_back(mb(ZLOWIN, '0, b, i[31:27], 4'd4));
            mq.push_back(mb(ZLOWOUT, a, '0, '0, 4'd5));
        end else begin
            t = mb('0, '0, '0, '0, 4'd4);
            t.to_halt = (opv == 27);
            t.set_ill = (opv != 26 && opv != 27);
            mq.push_back(t);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_halt = 1'b0;
        m_ill = 1'b0;
    endtask

    task automatic model_step();
        bnd_t cur;
        if (m_halt) return;
        if (mq.size() == 0) begin
            if (run) push_fetch();
            return;
        end
        cur = mq.pop_front();
        if (cur.set_ill) m_ill = 1'b1;
        if (cur.to_halt) m_halt = 1'b1;
        else if (cur.st == 4'd3) push_exec(ir);
        else if (mq.size() == 0 && run) push_fetch();
    endtask

    function automatic logic [31:0] rand_ir();
        int unsigned k;
        logic [4:0] o;
        k = $urandom_range(0, 19);
        if (k < 8)       o = 5'($urandom_range(3, 11));
        else if (k < 10) o = 5'($urandom_range(15, 16));
        else if (k < 12) o = 5'($urandom_range(17, 18));
        else if (k < 14) o = 5'd26;
        else if (k < 15) o = 5'd27;
        else begin
            o = 5'($urandom_range(0, 31));
            while ((o >= 3 && o <= 11) || (o >= 15 && o <= 18) || o == 26 || o == 27)
                o = 5'($urandom_range(0, 31));
        end
        return {o, 27'($urandom)};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        run;
        logic [31:0] ir;
        logic [3:0]  st;
        logic [13:0] s;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
        logic        ill;
    } vec_t;

    function automatic vec_t v(input logic r, input logic [31:0] i, input logic [3:0] st,
                               input logic [13:0] s, input logic [15:0] rin,
                               input logic [15:0] rout, input logic [4:0] op, input logic ill);
        vec_t x;
        x.run = r; x.ir = i; x.st = st; x.s = s; x.rin = rin; x.rout = rout; x.op = op; x.ill = ill;
        return x;
    endfunction

    vec_t tbl[39];
    logic [55:0] wexp[5];

    initial begin
        tbl[0]  = v(0, ADD, 0, '0, '0, '0, '0, 0);
        tbl[1]  = v(1, ADD, 1, F_T0, '0, '0, 5'h1f, 0);
        tbl[2]  = v(1, ADD, 2, F_T1, '0, '0, '0, 0);
        tbl[3]  = v(1, ADD, 3, F_T2, '0, '0, '0, 0);
        tbl[4]  = v(1, ADD, 4, YIN, '0, 16'h0008, '0, 0);
        tbl[5]  = v(1, ADD, 5, ZLOWIN, '0, 16'h0080, 5'd3, 0);
        tbl[6]  = v(1, ADD, 6, ZLOWOUT, 16'h0010, '0, '0, 0);
        tbl[7]  = v(1, SUB, 1, F_T0, '0, '0, 5'h1f, 0);
        tbl[8]  = v(1, SUB, 2, F_T1, '0, '0, '0, 0);
        tbl[9]  = v(1, SUB, 3, F_T2, '0, '0, '0, 0);
        tbl[10] = v(1, SUB, 4, YIN, '0, 16'h0008, '0, 0);
        tbl[11] = v(1, SUB, 5, ZLOWIN, '0, 16'h0080, 5'd4, 0);
        tbl[12] = v(0, SUB, 6, ZLOWOUT, 16'h0010, '0, '0, 0);
        tbl[13] = v(0, SUB, 0, '0, '0, '0, '0, 0);
        tbl[14] = v(0, MUL, 0, '0, '0, '0, '0, 0);
        tbl[15] = v(1, MUL, 1, F_T0, '0, '0, 5'h1f, 0);
        tbl[16] = v(1, MUL, 2, F_T1, '0, '0, '0, 0);
        tbl[17] = v(1, MUL, 3, F_T2, '0, '0, '0, 0);
        tbl[18] = v(1, MUL, 4, YIN, '0, 16'h0008, '0, 0);
        tbl[19] = v(1, MUL, 5, ZLOWIN | ZHIGHIN, '0, 16'h0080, 5'd15, 0);
        tbl[20] = v(1, MUL, 6, ZLOWOUT | LOIN, '0, '0, '0, 0);
        tbl[21] = v(0, MUL, 7, ZHIGHOUT | HIIN, '0, '0, '0, 0);
        tbl[22] = v(0, MUL, 0, '0, '0, '0, '0, 0);
        tbl[23] = v(1, BAD, 1, F_T0, '0, '0, 5'h1f, 0);
        tbl[24] = v(1, BAD, 2, F_T1, '0, '0, '0, 0);
        tbl[25] = v(1, BAD, 3, F_T2, '0, '0, '0, 0);
        tbl[26] = v(1, BAD, 4, '0, '0, '0, '0, 0);
        tbl[27] = v(1, BAD, 1, F_T0, '0, '0, 5'h1f, 1);
        tbl[28] = v(0, BAD, 2, F_T1, '0, '0, '0, 1);
        tbl[29] = v(0, BAD, 3, F_T2, '0, '0, '0, 1);
        tbl[30] = v(0, BAD, 4, '0, '0, '0, '0, 1);
        tbl[31] = v(0, BAD, 0, '0, '0, '0, '0, 1);
        tbl[32] = v(1, HLT, 1, F_T0, '0, '0, 5'h1f, 1);
        tbl[33] = v(1, HLT, 2, F_T1, '0, '0, '0, 1);
        tbl[34] = v(1, HLT, 3, F_T2, '0, '0, '0, 1);
        tbl[35] = v(1, HLT, 4, '0, '0, '0, '0, 1);
        tbl[36] = v(1, HLT, 8, '0, '0, '0, '0, 1);
        tbl[37] = v(0, HLT, 8, '0, '0, '0, '0, 1);
        tbl[38] = v(1, HLT, 8, '0, '0, '0, '0, 1);

        wexp[0] = mkobs(F_T0, '0, '0, 5'h1f, 4'd1);
        wexp[1] = mkobs(F_T1, '0, '0, '0, 4'd2);
        wexp[2] = mkobs(READ | MDRIN, '0, '0, '0, 4'd2);
        wexp[3] = mkobs(READ | MDRIN, '0, '0, '0, 4'd2);
        wexp[4] = mkobs(F_T2, '0, '0, '0, 4'd3);

        // reset state
        clear = 1'b0;
        run = 1'b0;
        @(negedge clock);
        chk("reset_outputs", obs0, '0);
        chk1("reset_illegal", a_illegal, 1'b0);
        chk("reset_outputs_w", obsw, '0);
        clear = 1'b1;

        foreach (tbl[i]) begin
            run = tbl[i].run;
            ir = tbl[i].ir;
            @(negedge clock);
            chk($sformatf("tbl[%0d]", i), obs0,
                mkobs(tbl[i].s, tbl[i].rin, tbl[i].rout, tbl[i].op, tbl[i].st));
            chk1($sformatf("tbl_ill[%0d]", i), a_illegal, tbl[i].ill);
        end

        // clear releases HALT
        #2 clear = 1'b0;
        #1;
        chk("halt_clear", obs0, '0);
        chk1("halt_clear_ill", a_illegal, 1'b0);

        // async clear in the middle of an add, with illegal already set
        @(negedge clock);
        clear = 1'b1;
        run = 1'b1;
        ir = BAD;
        repeat (5) @(negedge clock);
        ir = ADD;
        repeat (4) @(negedge clock);
        chk("pre_clear_t4", obs0, mkobs(ZLOWIN, '0, 16'h0080, 5'd3, 4'd5));
        chk1("pre_clear_ill", a_illegal, 1'b1);
        #2 clear = 1'b0;
        #1;
        chk("async_clear", obs0, '0);
        chk1("async_clear_ill", a_illegal, 1'b0);
        @(negedge clock);
        chk("held_clear", obs0, '0);
        clear = 1'b1;
        @(negedge clock);
        chk("resume_t0", obs0, mkobs(F_T0, '0, '0, 5'h1f, 4'd1));

        // MEM_WAIT=2 stretches T1
        clear = 1'b0;
        run = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        run = 1'b1;
        ir = ADD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("memwait[%0d]", i), obsw, wexp[i]);
        end

        // randomized run against the model
        clear = 1'b0;
        run = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bnd_t cur;
            @(negedge clock);
            cur = m_cur();
            chk("rand_out", obs0, bobs(cur));
            chk1("rand_ill", a_illegal, m_ill);
            if (cur.st == 4'd8) clear = ($urandom_range(0, 3) != 0);
            else clear = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) run = ~run;
            if (cur.st <= 4'd3 && $urandom_range(0, 1) == 0) ir = rand_ir();
            if (!clear) model_reset();
            else model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
